// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and defaults for the register-file write-back arbiter.
// Requester encodings double as the round-robin last-grant pointer values.
package regfile_wb_arbiter_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;
  localparam int NUM_REGS   = 2 ** DEF_ADDR_W;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LD  = 1'b1
  } req_e;

  // Ties go to whichever side was not granted last.
  function automatic logic [1:0] rr_pick(
    input logic [1:0] req,
    input req_e       last
  );
    logic [1:0] pick;
    pick = req;
    if (req == 2'b11) begin
      pick = (last == REQ_ALU) ? 2'b10 : 2'b01;
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a last-grant pointer register.
// req[0]/gnt[0] is REQ_ALU, req[1]/gnt[1] is REQ_LD.
module rr_arb2
  import regfile_wb_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       block,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  req_e last;

  always_comb begin
    gnt = 2'b00;
    if (!reset && !block) begin
      gnt = rr_pick(req, last);
    end
  end

  // A grant is always an accept: grants only go to valid requesters.
  always_ff @(posedge clk) begin
    if (reset) begin
      last <= REQ_ALU;
    end else if (gnt[1]) begin
      last <= REQ_LD;
    end else if (gnt[0]) begin
      last <= REQ_ALU;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file write port, plus the
// pending-write scoreboard decode uses for RAW stalls.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [ADDR_W-1:0]    alu_addr,
  input  logic [DATA_W-1:0]    alu_data,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [ADDR_W-1:0]    ld_addr,
  input  logic [DATA_W-1:0]    ld_data,
  input  logic                 rd2_claim,
  input  logic                 rsv_valid,
  input  logic [ADDR_W-1:0]    rsv_addr,
  output logic                 rf_regwrite,
  output logic [ADDR_W-1:0]    rf_waddr,
  output logic [DATA_W-1:0]    rf_wd,
  output logic                 rf_port_busy,
  output logic [2**ADDR_W-1:0] pending
);

  localparam int NREG = 2 ** ADDR_W;

  logic [1:0]        gnt;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [NREG-1:0]   pend_nxt;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .block (rd2_claim),
    .req   ({ld_valid, alu_valid}),
    .gnt   (gnt)
  );

  assign alu_ready    = gnt[0];
  assign ld_ready     = gnt[1];
  assign rf_port_busy = rf_regwrite;

  always_comb begin
    sel_addr = alu_addr;
    sel_data = alu_data;
    if (gnt[1]) begin
      sel_addr = ld_addr;
      sel_data = ld_data;
    end
  end

  // r0 writes complete the handshake but never reach the file.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_regwrite <= 1'b0;
      rf_waddr    <= '0;
      rf_wd       <= '0;
    end else if (|gnt) begin
      rf_regwrite <= (sel_addr != '0);
      rf_waddr    <= sel_addr;
      rf_wd       <= sel_data;
    end else begin
      rf_regwrite <= 1'b0;
    end
  end

  // Set after clear: a fresh reservation outlives the old commit.
  always_comb begin
    pend_nxt = pending;
    if (rf_regwrite) begin
      pend_nxt[rf_waddr] = 1'b0;
    end
    if (rsv_valid && (rsv_addr != '0)) begin
      pend_nxt[rsv_addr] = 1'b1;
    end
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= pend_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: per-cycle model compare
// plus directed scenarios with literal expectations.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic        alu_ready;
  logic [3:0]  alu_addr;
  logic [15:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [3:0]  ld_addr;
  logic [15:0] ld_data;
  logic        rd2_claim;
  logic        rsv_valid;
  logic [3:0]  rsv_addr;
  logic        rf_regwrite;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wd;
  logic        rf_port_busy;
  logic [15:0] pending;

  int npass = 0;
  int ntot  = 0;

  regfile_wb_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_addr     (alu_addr),
    .alu_data     (alu_data),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .rd2_claim    (rd2_claim),
    .rsv_valid    (rsv_valid),
    .rsv_addr     (rsv_addr),
    .rf_regwrite  (rf_regwrite),
    .rf_waddr     (rf_waddr),
    .rf_wd        (rf_wd),
    .rf_port_busy (rf_port_busy),
    .pending      (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Environment register file: writes whenever write enable is high,
  // so a leaked r0 write would be visible on a read of r0.
  logic [15:0] envrf [16];
  always @(posedge clk) begin
    if (rf_regwrite) envrf[rf_waddr] <= rf_wd;
  end
  initial for (int i = 0; i < 16; i++) envrf[i] = 16'h0;

  // Behavioural model: who was granted last, and the expected
  // registered outputs and pending mask after each edge.
  bit          m_last_ld = 1'b0;
  bit          m_we      = 1'b0;
  logic [3:0]  m_addr    = 4'h0;
  logic [15:0] m_data    = 16'h0;
  logic [15:0] m_pend    = 16'h0;

  function automatic bit want_alu();
    if (reset || rd2_claim || !alu_valid) return 1'b0;
    if (!ld_valid) return 1'b1;
    return m_last_ld;
  endfunction

  function automatic bit want_ld();
    if (reset || rd2_claim || !ld_valid) return 1'b0;
    if (!alu_valid) return 1'b1;
    return !m_last_ld;
  endfunction

  always @(posedge clk) begin
    bit wa, wl;
    wa = want_alu();
    wl = want_ld();
    if (reset) begin
      m_last_ld = 1'b0;
      m_we = 1'b0;
      m_addr = 4'h0;
      m_data = 16'h0;
      m_pend = 16'h0;
    end else begin
      if (m_we) m_pend[m_addr] = 1'b0;
      if (rsv_valid && rsv_addr != 4'h0) m_pend[rsv_addr] = 1'b1;
      if (wa) begin
        m_we = (alu_addr != 4'h0);
        m_addr = alu_addr;
        m_data = alu_data;
        m_last_ld = 1'b0;
      end else if (wl) begin
        m_we = (ld_addr != 4'h0);
        m_addr = ld_addr;
        m_data = ld_data;
        m_last_ld = 1'b1;
      end else begin
        m_we = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("alu_ready", 32'(alu_ready), 32'(want_alu()));
    chk("ld_ready", 32'(ld_ready), 32'(want_ld()));
    chk("rf_regwrite", 32'(rf_regwrite), 32'(m_we));
    chk("rf_port_busy", 32'(rf_port_busy), 32'(m_we));
    chk("rf_waddr", 32'(rf_waddr), 32'(m_addr));
    chk("rf_wd", 32'(rf_wd), 32'(m_data));
    chk("pending", 32'(pending), 32'(m_pend));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
    rd2_claim = 1'b0;
    rsv_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    alu_valid = 1'b1; alu_addr = 4'h1; alu_data = 16'h1111;
    ld_valid  = 1'b1; ld_addr  = 4'h2; ld_data  = 16'h2222;
    rd2_claim = 1'b0; rsv_valid = 1'b1; rsv_addr = 4'h6;
    tick();
    tick();
    #2;
    chk("rst_alu_ready", 32'(alu_ready), 32'h0);
    chk("rst_ld_ready", 32'(ld_ready), 32'h0);
    chk("rst_regwrite", 32'(rf_regwrite), 32'h0);
    chk("rst_pending", 32'(pending), 32'h0);
    idle();
    tick();
    reset = 1'b0;
    tick();

    // ALU alone to r3
    alu_valid = 1'b1; alu_addr = 4'h3; alu_data = 16'h00A5;
    #2;
    chk("alu_only_ready", 32'(alu_ready), 32'h1);
    tick();
    alu_valid = 1'b0;
    #2;
    chk("alu_only_we", 32'(rf_regwrite), 32'h1);
    chk("alu_only_waddr", 32'(rf_waddr), 32'h3);
    chk("alu_only_wd", 32'(rf_wd), 32'h00A5);
    tick();
    #2;
    chk("alu_only_rd2_r3", 32'(envrf[3]), 32'h00A5);

    // Contention from reset: LD, ALU, LD, ALU
    do_reset();
    begin
      int ai, li;
      logic [15:0] last_wd;
      ai = 0; li = 0; last_wd = 16'h0;
      for (int i = 0; i < 4; i++) begin
        alu_valid = 1'b1; alu_addr = 4'h1;
        alu_data = 16'(16'h1000 + ai);
        ld_valid = 1'b1; ld_addr = 4'h2;
        ld_data = 16'(16'h2000 + li);
        #2;
        chk("tie_ld_ready", 32'(ld_ready), 32'(i % 2 == 0));
        chk("tie_alu_ready", 32'(alu_ready), 32'(i % 2 == 1));
        if (i > 0) chk("tie_wd", 32'(rf_wd), 32'(last_wd));
        if (i % 2 == 0) begin
          last_wd = 16'(16'h2000 + li);
          li++;
        end else begin
          last_wd = 16'(16'h1000 + ai);
          ai++;
        end
        tick();
      end
      idle();
      #2;
      chk("tie_wd_last", 32'(rf_wd), 32'h1001);
      chk("tie_waddr_last", 32'(rf_waddr), 32'h1);
    end
    tick();

    // rd2_claim holds off the ALU for two cycles
    alu_valid = 1'b1; alu_addr = 4'h4; alu_data = 16'h0444;
    rd2_claim = 1'b1;
    #2;
    chk("claim_alu_ready0", 32'(alu_ready), 32'h0);
    tick();
    #2;
    chk("claim_busy0", 32'(rf_port_busy), 32'h0);
    chk("claim_alu_ready1", 32'(alu_ready), 32'h0);
    tick();
    rd2_claim = 1'b0;
    #2;
    chk("claim_busy1", 32'(rf_port_busy), 32'h0);
    chk("claim_alu_ready2", 32'(alu_ready), 32'h1);
    tick();
    alu_valid = 1'b0;
    #2;
    chk("claim_busy2", 32'(rf_port_busy), 32'h1);
    chk("claim_waddr", 32'(rf_waddr), 32'h4);
    tick();

    // Scoreboard: reserve r5, commit, re-reserve on the clearing edge
    rsv_valid = 1'b1; rsv_addr = 4'h5;
    tick();
    rsv_valid = 1'b0;
    #2;
    chk("pend_set", 32'(pending), 32'h0020);
    alu_valid = 1'b1; alu_addr = 4'h5; alu_data = 16'h0055;
    tick();
    alu_valid = 1'b0;
    rsv_valid = 1'b1; rsv_addr = 4'h5;
    #2;
    chk("pend_before_clear", 32'(pending), 32'h0020);
    tick();
    rsv_valid = 1'b0;
    #2;
    chk("pend_set_wins", 32'(pending), 32'h0020);
    alu_valid = 1'b1; alu_addr = 4'h5; alu_data = 16'h0056;
    tick();
    alu_valid = 1'b0;
    tick();
    #2;
    chk("pend_cleared", 32'(pending), 32'h0000);

    // r0 write and r0 reservation are discarded
    ld_valid = 1'b1; ld_addr = 4'h0; ld_data = 16'hFFFF;
    rsv_valid = 1'b1; rsv_addr = 4'h0;
    #2;
    chk("r0_ld_ready", 32'(ld_ready), 32'h1);
    tick();
    idle();
    #2;
    chk("r0_regwrite", 32'(rf_regwrite), 32'h0);
    chk("r0_pending", 32'(pending), 32'h0000);
    tick();
    #2;
    chk("r0_rd1", 32'(envrf[0]), 32'h0);

    // Reset with a write in flight and a reservation outstanding
    alu_valid = 1'b1; alu_addr = 4'h7; alu_data = 16'h0077;
    rsv_valid = 1'b1; rsv_addr = 4'h7;
    tick();
    idle();
    reset = 1'b1;
    #2;
    chk("midrst_ready", 32'(ld_ready | alu_ready), 32'h0);
    tick();
    reset = 1'b0;
    #2;
    chk("midrst_we", 32'(rf_regwrite), 32'h0);
    chk("midrst_pend", 32'(pending), 32'h0);

    // Mixed traffic, checked by the per-cycle model
    for (int i = 0; i < 48; i++) begin
      bit a_acc, l_acc;
      if (!alu_valid && (i % 3 != 2)) begin
        alu_valid = 1'b1;
        alu_addr = i[3:0];
        alu_data = 16'(16'h3000 + i);
      end
      if (!ld_valid && (i % 4 != 1)) begin
        ld_valid = 1'b1;
        ld_addr = 4'(i + 7);
        ld_data = 16'(16'h4000 + i);
      end
      rd2_claim = (i % 7 == 4);
      rsv_valid = (i % 3 == 0);
      rsv_addr = 4'(i * 5);
      #2;
      a_acc = alu_valid && alu_ready;
      l_acc = ld_valid && ld_ready;
      tick();
      if (a_acc) alu_valid = 1'b0;
      if (l_acc) ld_valid = 1'b0;
    end
    idle();
    tick();
    tick();
    tick();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
